fft_job_sequencer: RTL

//  Sequences one FFT job end to end: host read, compute, then host write-back.

---
 rtl/fft_ctrl_pkg.sv | 31 +++
 rtl/seq_chunker.sv | 28 ++
 rtl/fft_job_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types for the FFT job sequencer: FSM states, descriptor layout and
// the chunk-size helper used wherever a chunk length has to be derived.
package fft_ctrl_pkg;

  localparam int CL_ADDR_W       = 42;
  localparam int LEN_W           = 64;
  localparam int CHUNK_LINES_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_GO,
    S_RD_WAIT,
    S_PR_GO,
    S_PR_WAIT,
    S_WR_GO,
    S_WR_WAIT,
    S_NEXT
  } t_seq_state;

  typedef struct packed {
    logic [CL_ADDR_W-1:0] src;
    logic [CL_ADDR_W-1:0] dst;
    logic [LEN_W-1:0]     lines;
  } t_fft_desc;

  function automatic logic [LEN_W-1:0] chunk_of(input logic [LEN_W-1:0] rem,
                                                input logic [LEN_W-1:0] lim);
    return (rem < lim) ? rem : lim;
  endfunction

endpackage

// File: rtl/seq_chunker.sv
// Chunk arithmetic: advances src/dst/remaining past the current chunk and
// sizes the chunk that follows it. Addresses wrap modulo 2^42.
module seq_chunker
  import fft_ctrl_pkg::*;
#(
  parameter int CHUNK_LINES = CHUNK_LINES_DEF
) (
  input  logic [CL_ADDR_W-1:0] i_src,
  input  logic [CL_ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]     i_rem,
  output logic [CL_ADDR_W-1:0] o_nxt_src,
  output logic [CL_ADDR_W-1:0] o_nxt_dst,
  output logic [LEN_W-1:0]     o_nxt_rem,
  output logic [LEN_W-1:0]     o_nxt_chunk
);

  logic [LEN_W-1:0] w_chunk;

  // CHUNK_LINES never exceeds 2^16, so the chunk fits the address width
  always_comb begin
    w_chunk     = chunk_of(i_rem, LEN_W'(CHUNK_LINES));
    o_nxt_src   = i_src + CL_ADDR_W'(w_chunk);
    o_nxt_dst   = i_dst + CL_ADDR_W'(w_chunk);
    o_nxt_rem   = i_rem - w_chunk;
    o_nxt_chunk = chunk_of(o_nxt_rem, LEN_W'(CHUNK_LINES));
  end

endmodule

// File: rtl/fft_job_sequencer.sv
// Runs one FFT job as a series of chunks, each going read -> FFT -> write
// through the three engines' run/done handshakes, one chunk in flight.
module fft_job_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int CHUNK_LINES = CHUNK_LINES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [41:0]      desc_src,
  input  logic [41:0]      desc_dst,
  input  logic [63:0]      desc_lines,
  input  logic             stop_req,
  output logic             rd_run,
  output logic [41:0]      rd_first_clAddr,
  output logic [63:0]      rd_length,
  input  logic             rd_done,
  output logic             proc_start,
  input  logic             proc_done,
  output logic             wr_run,
  output logic [41:0]      wr_first_clAddr,
  output logic [63:0]      wr_length,
  input  logic             wr_done,
  output logic             busy,
  output logic             job_done,
  output logic             job_stopped,
  output logic [CNT_W-1:0] jobs_completed
);

  t_seq_state r_state, w_next;
  t_fft_desc  r_cur;

  logic             r_rd_run, r_proc_start, r_wr_run;
  logic             r_job_done, r_job_stopped;
  logic [CNT_W-1:0] r_jobs;
  logic [41:0]      r_rd_addr, r_wr_addr;
  logic [63:0]      r_rd_len, r_wr_len;

  logic             w_accept, w_job_end, w_stop_end;
  logic [41:0]      w_nxt_src, w_nxt_dst, w_ld_src;
  logic [63:0]      w_nxt_rem, w_nxt_chunk, w_ld_len;

  seq_chunker #(.CHUNK_LINES(CHUNK_LINES)) u_chunker (
    .i_src       (r_cur.src),
    .i_dst       (r_cur.dst),
    .i_rem       (r_cur.lines),
    .o_nxt_src   (w_nxt_src),
    .o_nxt_dst   (w_nxt_dst),
    .o_nxt_rem   (w_nxt_rem),
    .o_nxt_chunk (w_nxt_chunk)
  );

  // Done inputs are only looked at in the WAIT states, never in a GO cycle
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_job_end  = 1'b0;
    w_stop_end = 1'b0;
    w_ld_src   = w_nxt_src;
    w_ld_len   = w_nxt_chunk;
    case (r_state)
      S_IDLE: begin
        w_ld_src = desc_src;
        w_ld_len = chunk_of(desc_lines, 64'(CHUNK_LINES));
        if (desc_valid) begin
          w_accept = 1'b1;
          if (desc_lines == 64'd0) w_job_end = 1'b1;
          else                     w_next    = S_RD_GO;
        end
      end
      S_RD_GO:   w_next = S_RD_WAIT;
      S_RD_WAIT: if (rd_done)   w_next = S_PR_GO;
      S_PR_GO:   w_next = S_PR_WAIT;
      S_PR_WAIT: if (proc_done) w_next = S_WR_GO;
      S_WR_GO:   w_next = S_WR_WAIT;
      S_WR_WAIT: if (wr_done)   w_next = S_NEXT;
      S_NEXT: begin
        if ((w_nxt_rem == 64'd0) || stop_req) begin
          w_job_end  = 1'b1;
          w_stop_end = stop_req && (w_nxt_rem != 64'd0);
          w_next     = S_IDLE;
        end else begin
          w_next = S_RD_GO;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Engine-facing address/length registers change only when entering a GO state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cur         <= '0;
      r_rd_run      <= 1'b0;
      r_proc_start  <= 1'b0;
      r_wr_run      <= 1'b0;
      r_job_done    <= 1'b0;
      r_job_stopped <= 1'b0;
      r_jobs        <= '0;
      r_rd_addr     <= '0;
      r_rd_len      <= '0;
      r_wr_addr     <= '0;
      r_wr_len      <= '0;
    end else begin
      r_state       <= w_next;
      r_rd_run      <= (w_next == S_RD_GO);
      r_proc_start  <= (w_next == S_PR_GO);
      r_wr_run      <= (w_next == S_WR_GO);
      r_job_done    <= w_job_end;
      r_job_stopped <= w_stop_end;
      if (w_job_end) r_jobs <= r_jobs + CNT_W'(1);
      if (w_accept) begin
        r_cur <= '{src: desc_src, dst: desc_dst, lines: desc_lines};
      end else if (r_state == S_NEXT) begin
        r_cur <= '{src: w_nxt_src, dst: w_nxt_dst, lines: w_nxt_rem};
      end
      if (w_next == S_RD_GO) begin
        r_rd_addr <= w_ld_src;
        r_rd_len  <= w_ld_len;
      end
      if (w_next == S_WR_GO) begin
        r_wr_addr <= r_cur.dst;
        r_wr_len  <= r_rd_len;
      end
    end
  end

  assign desc_ready      = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign rd_run          = r_rd_run;
  assign rd_first_clAddr = r_rd_addr;
  assign rd_length       = r_rd_len;
  assign proc_start      = r_proc_start;
  assign wr_run          = r_wr_run;
  assign wr_first_clAddr = r_wr_addr;
  assign wr_length       = r_wr_len;
  assign job_done        = r_job_done;
  assign job_stopped     = r_job_stopped;
  assign jobs_completed  = r_jobs;

endmodule
